// File: rtl/aes_128_core_ctrl.sv
// Command sequencer for the AES-128 core: turns host init/next commands into
// key-expansion / encipher start strobes, owns the S-box select and captures the result.
module aes_128_core_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic         next,
    output logic         ready,
    output logic         key_valid,
    output logic [127:0] result,
    output logic         result_valid,
    output logic         cmd_err,
    output logic         timeout_err,
    output logic         key_init,
    input  logic         key_ready,
    output logic         enc_next,
    input  logic         enc_ready,
    input  logic [127:0] enc_new_block,
    output logic         sbox_sel
);

    typedef enum logic [2:0] {
        IDLE,
        KEY_START,
        KEY_WAIT,
        ENC_START,
        ENC_WAIT
    } state_t;

    // The watchdog holds the number of wait cycles already spent, so the abort
    // fires on the edge where that count would reach TIMEOUT_CYCLES.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t         state_reg;
    logic           next_pending_reg;
    logic [7:0]     wdog_reg;
    logic           key_valid_reg;
    logic           result_valid_reg;
    logic [127:0]   result_reg;
    logic           cmd_err_reg;
    logic           timeout_err_reg;
    logic           wdog_expired;

    assign wdog_expired = (wdog_reg == WDOG_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            next_pending_reg <= 1'b0;
            wdog_reg         <= 8'd0;
            key_valid_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
            result_reg       <= '0;
            cmd_err_reg      <= 1'b0;
            timeout_err_reg  <= 1'b0;
        end else begin
            cmd_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (init) begin
                        state_reg        <= KEY_START;
                        key_valid_reg    <= 1'b0;
                        result_valid_reg <= 1'b0;
                        next_pending_reg <= next;
                    end else if (next) begin
                        if (key_valid_reg) begin
                            state_reg        <= ENC_START;
                            result_valid_reg <= 1'b0;
                        end else begin
                            cmd_err_reg <= 1'b1;
                        end
                    end
                end
                KEY_START: begin
                    state_reg <= KEY_WAIT;
                    wdog_reg  <= 8'd0;
                    if (init) cmd_err_reg <= 1'b1;
                    if (next) next_pending_reg <= 1'b1;
                end
                KEY_WAIT: begin
                    if (init) cmd_err_reg <= 1'b1;
                    if (key_ready) begin
                        key_valid_reg <= 1'b1;
                        // A next arriving on the completion edge is honoured too.
                        if (next_pending_reg || next) begin
                            next_pending_reg <= 1'b0;
                            result_valid_reg <= 1'b0;
                            state_reg        <= ENC_START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (wdog_expired) begin
                        timeout_err_reg  <= 1'b1;
                        next_pending_reg <= 1'b0;
                        key_valid_reg    <= 1'b0;
                        state_reg        <= IDLE;
                    end else begin
                        wdog_reg <= wdog_reg + 8'd1;
                        if (next) next_pending_reg <= 1'b1;
                    end
                end
                ENC_START: begin
                    state_reg <= ENC_WAIT;
                    wdog_reg  <= 8'd0;
                    if (init || next) cmd_err_reg <= 1'b1;
                end
                ENC_WAIT: begin
                    if (init || next) cmd_err_reg <= 1'b1;
                    if (enc_ready) begin
                        result_reg       <= enc_new_block;
                        result_valid_reg <= 1'b1;
                        state_reg        <= IDLE;
                    end else if (wdog_expired) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        wdog_reg <= wdog_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready        = (state_reg == IDLE);
    assign key_init     = (state_reg == KEY_START);
    assign enc_next     = (state_reg == ENC_START);
    assign sbox_sel     = (state_reg == ENC_START) || (state_reg == ENC_WAIT);
    assign key_valid    = key_valid_reg;
    assign result_valid = result_valid_reg;
    assign result       = result_reg;
    assign cmd_err      = cmd_err_reg;
    assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_aes_128_core_ctrl.sv
// Randomized bench for aes_128_core_ctrl: latency-driven key/encipher models plus a
// transaction-level prediction of pulses, timing and result registers.
module tb_aes_128_core_ctrl;

    localparam int TO = 60;
    localparam logic [127:0] FIPS_CT = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         init = 1'b0;
    logic         next = 1'b0;
    logic         ready, key_valid, result_valid, cmd_err, timeout_err;
    logic         key_init, enc_next, sbox_sel;
    logic [127:0] result;
    logic         key_ready = 1'b1;
    logic         enc_ready = 1'b1;
    logic [127:0] enc_new_block = '0;

    aes_128_core_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .next(next),
        .ready(ready), .key_valid(key_valid), .result(result),
        .result_valid(result_valid), .cmd_err(cmd_err), .timeout_err(timeout_err),
        .key_init(key_init), .key_ready(key_ready), .enc_next(enc_next),
        .enc_ready(enc_ready), .enc_new_block(enc_new_block), .sbox_sel(sbox_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream models: ready drops after the start pulse and returns `lat` cycles after it.
    int           key_lat = 10, key_cnt = 0;
    bit           key_hang = 0;
    int           enc_lat = 10, enc_cnt = 0;
    bit           enc_hang = 0;
    logic [127:0] enc_blk = '0;

    always @(posedge clk) begin
        if (!reset_n) begin
            key_ready <= 1'b1;
            key_cnt   <= 0;
        end else if (key_init) begin
            key_ready <= 1'b0;
            key_cnt   <= key_hang ? 0 : key_lat - 1;
        end else if (key_cnt > 0) begin
            key_cnt <= key_cnt - 1;
            if (key_cnt == 1) key_ready <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            enc_ready <= 1'b1;
            enc_cnt   <= 0;
        end else if (enc_next) begin
            enc_ready     <= 1'b0;
            enc_new_block <= ~enc_blk;
            enc_cnt       <= enc_hang ? 0 : enc_lat - 1;
        end else if (enc_cnt > 0) begin
            enc_cnt <= enc_cnt - 1;
            if (enc_cnt == 1) begin
                enc_ready     <= 1'b1;
                enc_new_block <= enc_blk;
            end
        end
    end

    // Pulse counters and event timestamps, sampled mid-cycle.
    int   n_key_init = 0, n_enc_next = 0, n_cmd_err = 0, n_timeout = 0, n_sbox = 0;
    int   key_init_cyc = -1, enc_next_cyc = -1, rv_rise_cyc = -1, timeout_cyc = -1;
    logic rv_prev = 1'b0;

    always @(negedge clk) begin
        if (key_init) begin n_key_init <= n_key_init + 1; key_init_cyc <= cyc; end
        if (enc_next) begin n_enc_next <= n_enc_next + 1; enc_next_cyc <= cyc; end
        if (cmd_err) n_cmd_err <= n_cmd_err + 1;
        if (timeout_err) begin n_timeout <= n_timeout + 1; timeout_cyc <= cyc; end
        if (sbox_sel) n_sbox <= n_sbox + 1;
        rv_prev <= result_valid;
        if (result_valid && !rv_prev) rv_rise_cyc <= cyc;
    end

    // Reference state at transaction level.
    bit           m_kv = 0;
    bit           m_rv = 0;
    logic [127:0] m_result = '0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check_eq({tag, "_ready"}, 128'(ready), 128'(1));
        step();
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_key_valid"}, 128'(key_valid), 128'(m_kv));
        check_eq({tag, "_result_valid"}, 128'(result_valid), 128'(m_rv));
        check_eq({tag, "_result"}, result, m_result);
    endtask

    task automatic do_init(input int klat, input bit khang);
        int b_ki, b_en, b_ce, b_to, b_sb, c;
        b_ki = n_key_init; b_en = n_enc_next; b_ce = n_cmd_err; b_to = n_timeout; b_sb = n_sbox;
        key_lat = klat; key_hang = khang;
        c = cyc;
        init = 1'b1; step(); init = 1'b0;
        wait_ready("init");
        check_eq("init_key_init_n", 128'(n_key_init - b_ki), 128'(1));
        check_eq("init_key_init_cyc", 128'(key_init_cyc), 128'(c + 1));
        check_eq("init_enc_next_n", 128'(n_enc_next - b_en), 128'(0));
        check_eq("init_cmd_err_n", 128'(n_cmd_err - b_ce), 128'(0));
        check_eq("init_sbox_n", 128'(n_sbox - b_sb), 128'(0));
        check_eq("init_timeout_n", 128'(n_timeout - b_to), 128'(khang));
        if (khang) check_eq("init_timeout_cyc", 128'(timeout_cyc), 128'(c + TO + 2));
        m_kv = !khang;
        m_rv = 0;
        check_state("init");
        $display("txn init lat=%0d hang=%0d key_valid=%0d", klat, khang, key_valid);
    endtask

    // extra: 0 none, 1 init during encipher, 2 next during encipher
    task automatic do_next(input int elat, input bit ehang, input logic [127:0] blk, input int extra);
        int b_en, b_ce, b_to, b_sb, c;
        bit done;
        b_en = n_enc_next; b_ce = n_cmd_err; b_to = n_timeout; b_sb = n_sbox;
        enc_lat = elat; enc_hang = ehang; enc_blk = blk;
        c = cyc;
        next = 1'b1; step(); next = 1'b0;
        if (m_kv) begin
            if (extra != 0) begin
                step(); step();
                init = (extra == 1); next = (extra == 2);
                step();
                init = 1'b0; next = 1'b0;
            end
            wait_ready("next");
            done = !ehang && elat <= TO;
            check_eq("next_enc_next_n", 128'(n_enc_next - b_en), 128'(1));
            check_eq("next_enc_next_cyc", 128'(enc_next_cyc), 128'(c + 1));
            check_eq("next_cmd_err_n", 128'(n_cmd_err - b_ce), 128'(extra != 0));
            check_eq("next_timeout_n", 128'(n_timeout - b_to), 128'(!done));
            if (done) begin
                check_eq("next_rv_cyc", 128'(rv_rise_cyc), 128'(c + elat + 2));
                check_eq("next_sbox_n", 128'(n_sbox - b_sb), 128'(elat + 1));
                m_result = blk;
                m_rv = 1;
            end else begin
                check_eq("next_timeout_cyc", 128'(timeout_cyc), 128'(c + TO + 2));
                check_eq("next_sbox_n", 128'(n_sbox - b_sb), 128'(TO + 1));
                m_rv = 0;
            end
        end else begin
            step(); step();
            check_eq("rej_cmd_err_n", 128'(n_cmd_err - b_ce), 128'(1));
            check_eq("rej_enc_next_n", 128'(n_enc_next - b_en), 128'(0));
            check_eq("rej_ready", 128'(ready), 128'(1));
        end
        check_state("next");
        $display("txn next lat=%0d hang=%0d extra=%0d result_valid=%0d result=%h",
                 elat, ehang, extra, result_valid, result);
    endtask

    // init, then next `gap` cycles later (optionally repeated once) while the key expands.
    task automatic do_init_next(input int klat, input int gap, input bit rep, input int elat,
                                input logic [127:0] blk);
        int b_ki, b_en, b_ce, b_sb, c;
        b_ki = n_key_init; b_en = n_enc_next; b_ce = n_cmd_err; b_sb = n_sbox;
        key_lat = klat; key_hang = 0;
        enc_lat = elat; enc_hang = 0; enc_blk = blk;
        c = cyc;
        for (int i = 0; i <= gap + 1; i++) begin
            init = (i == 0);
            next = (i == gap) || (rep && i == gap + 1);
            step();
        end
        init = 1'b0; next = 1'b0;
        wait_ready("ikn");
        check_eq("ikn_key_init_n", 128'(n_key_init - b_ki), 128'(1));
        check_eq("ikn_cmd_err_n", 128'(n_cmd_err - b_ce), 128'(0));
        check_eq("ikn_enc_next_n", 128'(n_enc_next - b_en), 128'(1));
        check_eq("ikn_enc_next_cyc", 128'(enc_next_cyc), 128'(c + klat + 2));
        check_eq("ikn_rv_cyc", 128'(rv_rise_cyc), 128'(c + klat + elat + 3));
        check_eq("ikn_sbox_n", 128'(n_sbox - b_sb), 128'(elat + 1));
        m_kv = 1; m_rv = 1; m_result = blk;
        check_state("ikn");
        $display("txn init+next klat=%0d gap=%0d rep=%0d elat=%0d result=%h",
                 klat, gap, rep, elat, result);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, 128'(ready), 128'(1));
        check_eq({tag, "_cmd_err"}, 128'(cmd_err), 128'(0));
        check_eq({tag, "_timeout_err"}, 128'(timeout_err), 128'(0));
        check_eq({tag, "_key_init"}, 128'(key_init), 128'(0));
        check_eq({tag, "_enc_next"}, 128'(enc_next), 128'(0));
        check_eq({tag, "_sbox_sel"}, 128'(sbox_sel), 128'(0));
        m_kv = 0; m_rv = 0; m_result = '0;
        check_state(tag);
        $display("txn reset %s", tag);
    endtask

    initial begin
        int op, klat;
        logic [127:0] blk;
        reset_n = 1'b0;
        step(); step(); step();
        check_reset_values("por");
        reset_n = 1'b1;
        step();

        do_next(10, 0, 128'h1111, 0);
        do_init(40, 0);
        do_next(52, 0, FIPS_CT, 0);
        do_init_next(20, 5, 1, 30, {$urandom, $urandom, $urandom, $urandom});
        do_next(30, 0, {$urandom, $urandom, $urandom, $urandom}, 1);
        do_next(30, 0, {$urandom, $urandom, $urandom, $urandom}, 2);
        do_next(TO, 0, {$urandom, $urandom, $urandom, $urandom}, 0);
        do_next(TO + 1, 0, {$urandom, $urandom, $urandom, $urandom}, 0);
        do_next(20, 1, {$urandom, $urandom, $urandom, $urandom}, 0);
        do_init(10, 1);
        do_next(10, 0, 128'h2222, 0);
        do_init(2, 0);
        do_init_next(8, 0, 1, 5, {$urandom, $urandom, $urandom, $urandom});

        for (int it = 0; it < 25; it++) begin
            op = $urandom_range(0, 3);
            blk = {$urandom, $urandom, $urandom, $urandom};
            case (op)
                0: do_init($urandom_range(2, 45), $urandom_range(0, 9) == 0);
                3: begin
                    klat = $urandom_range(2, 30);
                    do_init_next(klat, $urandom_range(0, klat - 1), 1'($urandom_range(0, 1)),
                                 $urandom_range(3, TO), blk);
                end
                default: do_next($urandom_range(3, TO + 2), $urandom_range(0, 9) == 0, blk,
                                 m_kv ? $urandom_range(0, 2) : 0);
            endcase
        end

        // Reset pulse in the middle of an encipher wait.
        if (!m_kv) do_init(5, 0);
        enc_lat = 50; enc_hang = 0; enc_blk = 128'h3333;
        next = 1'b1; step(); next = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_eq("mid_sbox_before_reset", 128'(sbox_sel), 128'(1));
        reset_n = 1'b0; step(); reset_n = 1'b1;
        check_reset_values("mid");
        step();
        do_next(10, 0, 128'h4444, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
